// File: rtl/processor_pkg.sv
// Types and constants shared by the Processor, the simulation harness and the instruction feeder.
package processor_pkg;

    localparam int WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        NO_OP   = 2'b00,
        EXECUTE = 2'b01,
        RESET   = 2'b11
    } operation_t;

    // True when the operation hands a fresh word to the Processor.
    function automatic logic op_issues(input operation_t op);
        return op == EXECUTE;
    endfunction

endpackage

// File: rtl/instruction_fifo.sv
// Circular instruction queue with push, pop and flush. The head word is read combinationally
// so the feeder can register it straight onto its output.
module instruction_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    // Storage carries no reset; only entries behind a valid count are ever read.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/instruction_feeder.sv
// Buffers host instruction words and issues one per cycle to the Processor, sequencing its RESET.
// Optional FEEDER_STALL_EN adds a stall input that holds issue while still accepting pushes.
module instruction_feeder
    import processor_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int WIDTH        = WORD_WIDTH,
    parameter int RESET_CYCLES = 1,
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pushValid,
    input  logic [WIDTH-1:0] pushInstruction,
    output logic             pushReady,
    input  logic             resetRequest,
`ifdef FEEDER_STALL_EN
    input  logic             stall,
`endif
    output operation_t       operation,
    output logic [WIDTH-1:0] nextInstruction,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    typedef logic [0:0] feeder_state_t;
    localparam feeder_state_t RST_PROC = 1'b0;
    localparam feeder_state_t RUN      = 1'b1;

    localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    feeder_state_t    state;
    logic [RCW-1:0]   rst_cnt;
    logic             halt;
    logic             push;
    logic             pop;
    logic             rst_done;
    logic [WIDTH-1:0] head;

`ifdef FEEDER_STALL_EN
    assign halt = stall;
`else
    assign halt = 1'b0;
`endif

    assign pushReady = (state == RUN) && !full;
    // A reset request wins over any coincident push or pop.
    assign push      = pushValid && pushReady && !resetRequest;
    assign pop       = (state == RUN) && !empty && !halt && !resetRequest;
    assign rst_done  = (rst_cnt == RCW'(RESET_CYCLES - 1));

    instruction_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (pushInstruction),
        .pop   (pop),
        .flush (resetRequest),
        .head  (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= RST_PROC;
            rst_cnt         <= '0;
            operation       <= RESET;
            nextInstruction <= '0;
        end else if (resetRequest) begin
            state           <= RST_PROC;
            rst_cnt         <= '0;
            operation       <= RESET;
            nextInstruction <= '0;
        end else if (state == RST_PROC) begin
            nextInstruction <= '0;
            if (rst_done) begin
                state     <= RUN;
                operation <= NO_OP;
            end else begin
                rst_cnt   <= rst_cnt + 1'b1;
                operation <= RESET;
            end
        end else if (pop) begin
            operation       <= EXECUTE;
            nextInstruction <= head;
        end else begin
            // EXECUTE would re-run a held word, so idle cycles must be NO_OP.
            operation       <= NO_OP;
            nextInstruction <= '0;
        end
    end

endmodule

// File: tb/tb_instruction_feeder.sv
// Directed bench for instruction_feeder; stall scenarios are built only with FEEDER_STALL_EN.
module tb_instruction_feeder;
    import processor_pkg::*;

    localparam int DEPTH = 16;
    localparam int RC    = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        pushValid;
    logic [31:0] pushInstruction;
    logic        pushReady;
    logic        resetRequest;
    logic        stall;
    operation_t  operation;
    logic [31:0] nextInstruction;
    logic [4:0]  count;
    logic        empty;
    logic        full;

    int total = 0;
    int bad   = 0;

    logic [31:0] q[$];
    int          mstate;
    int          mrst;
    logic        last_acc;

    instruction_feeder #(.DEPTH(DEPTH), .WIDTH(32), .RESET_CYCLES(RC)) dut (
        .clk             (clk),
        .reset           (reset),
        .pushValid       (pushValid),
        .pushInstruction (pushInstruction),
        .pushReady       (pushReady),
        .resetRequest    (resetRequest),
`ifdef FEEDER_STALL_EN
        .stall           (stall),
`endif
        .operation       (operation),
        .nextInstruction (nextInstruction),
        .count           (count),
        .empty           (empty),
        .full            (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock against the reference queue: check status before the edge, outputs after it.
    task automatic cyc();
        logic        rdy;
        logic        acc;
        logic [1:0]  eop;
        logic [31:0] enx;
        rdy = (mstate == 1) && (q.size() < DEPTH);
        chk("ready", {31'b0, pushReady}, {31'b0, rdy});
        chk("count", {27'b0, count}, q.size());
        chk("empty", {31'b0, empty}, {31'b0, q.size() == 0});
        chk("full",  {31'b0, full},  {31'b0, q.size() == DEPTH});
        acc = pushValid && rdy && !resetRequest;
        if (resetRequest) begin
            eop = 2'b11; enx = '0; q.delete(); mstate = 0; mrst = 0;
        end else if (mstate == 0) begin
            if (mrst == RC - 1) begin mstate = 1; eop = 2'b00; end
            else begin mrst++; eop = 2'b11; end
            enx = '0;
        end else if (q.size() > 0 && !stall) begin
            eop = 2'b01; enx = q.pop_front();
        end else begin
            eop = 2'b00; enx = '0;
        end
        if (acc) q.push_back(pushInstruction);
        last_acc = acc;
        tick();
        chk("op",   {30'b0, operation}, {30'b0, eop});
        chk("next", nextInstruction, enx);
    endtask

    task automatic push_word(input logic [31:0] w);
        pushValid = 1'b1;
        pushInstruction = w;
        last_acc = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (last_acc) break;
        end
        if (!last_acc) chk("push_timeout", 32'd0, 32'd1);
        pushValid = 1'b0;
    endtask

    task automatic idle(input int n);
        pushValid = 1'b0;
        repeat (n) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pushValid = 1'b0; pushInstruction = '0;
        resetRequest = 1'b0; stall = 1'b0;
        mstate = 0; mrst = 0; last_acc = 1'b0;

        // 1: reset state and RESET sequencing
        repeat (2) @(posedge clk);
        #1;
        chk("rst_op",    {30'b0, operation}, 32'h3);
        chk("rst_count", {27'b0, count}, 32'd0);
        chk("rst_ready", {31'b0, pushReady}, 32'd0);
        chk("rst_next",  nextInstruction, 32'd0);
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_full",  {31'b0, full}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rel_op", {30'b0, operation}, 32'h3);
        tick();
        chk("run_op",    {30'b0, operation}, 32'h0);
        chk("run_ready", {31'b0, pushReady}, 32'd1);
        mstate = 1;

        // 2: three words issue in order, then NO_OP
        pushValid = 1'b1; pushInstruction = 32'h24080001;
        tick();
        chk("t2_op0",  {30'b0, operation}, 32'h0);
        chk("t2_cnt0", {27'b0, count}, 32'd1);
        pushInstruction = 32'h24090002;
        tick();
        chk("t2_op1",  {30'b0, operation}, 32'h1);
        chk("t2_w1",   nextInstruction, 32'h24080001);
        pushInstruction = 32'h01095821;
        tick();
        chk("t2_op2",  {30'b0, operation}, 32'h1);
        chk("t2_w2",   nextInstruction, 32'h24090002);
        pushValid = 1'b0;
        tick();
        chk("t2_op3",  {30'b0, operation}, 32'h1);
        chk("t2_w3",   nextInstruction, 32'h01095821);
        chk("t2_empty", {31'b0, empty}, 32'd1);
        tick();
        chk("t2_op4",  {30'b0, operation}, 32'h0);
        chk("t2_w4",   nextInstruction, 32'h0);

        // 3: seventeen words, filling the queue when issue can be stalled
`ifdef FEEDER_STALL_EN
        stall = 1'b1;
        for (int i = 0; i < 16; i++) push_word(32'hA000_0000 + i);
        chk("t3_full",  {31'b0, full}, 32'd1);
        chk("t3_ready", {31'b0, pushReady}, 32'd0);
        chk("t3_count", {27'b0, count}, 32'd16);
        pushValid = 1'b1; pushInstruction = 32'hA000_0010;
        repeat (3) cyc();
        stall = 1'b0;
        push_word(32'hA000_0010);
        idle(20);
`else
        for (int i = 0; i < 17; i++) push_word(32'hA000_0000 + i);
        idle(3);
`endif
        chk("t3_drained", {27'b0, count}, 32'd0);

        // 4: push and pop together, then wrap the pointers
`ifdef FEEDER_STALL_EN
        stall = 1'b1;
        for (int i = 0; i < 5; i++) push_word(32'hB000_0000 + i);
        stall = 1'b0;
        chk("t4_cnt5", {27'b0, count}, 32'd5);
        push_word(32'hB000_0005);
        chk("t4_same", {27'b0, count}, 32'd5);
`endif
        for (int i = 0; i < 40; i++) push_word(32'hC000_0000 + i * 3);
        idle(8);
        chk("t4_drained", {27'b0, count}, 32'd0);

        // 5: reset request mid-stream flushes the queue and drops a coincident push
        push_word(32'hD000_0001);
        push_word(32'hD000_0002);
        push_word(32'hD000_0003);
        pushValid = 1'b1; pushInstruction = 32'hD000_0004; resetRequest = 1'b1;
        cyc();
        chk("t5_op",    {30'b0, operation}, 32'h3);
        chk("t5_count", {27'b0, count}, 32'd0);
        resetRequest = 1'b0;
        idle(4);
        pushValid = 1'b1; pushInstruction = 32'hD000_0005; resetRequest = 1'b1;
        repeat (3) cyc();
        chk("t5_hold_op",    {30'b0, operation}, 32'h3);
        chk("t5_hold_ready", {31'b0, pushReady}, 32'd0);
        resetRequest = 1'b0;
        idle(3);
        push_word(32'hD000_0006);
        idle(2);

`ifdef FEEDER_STALL_EN
        // 6: stall holds issue for three cycles, then both words go back-to-back
        stall = 1'b1;
        push_word(32'hE000_0001);
        push_word(32'hE000_0002);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t6_op",  {30'b0, operation}, 32'h0);
            chk("t6_cnt", {27'b0, count}, 32'd2);
        end
        stall = 1'b0;
        idle(3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
